exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/exec_unit_if.sv | 34 +++
 rtl/seq_mult.sv | 75 +++++++
 rtl/exec_unit.sv | 125 ++++++++++++
 tb/tb_exec_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the integer pipeline: ALU operation select and
// multiplier sequencer states, plus small decode helpers.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_MFHI  = 4'd11,
    ALU_MFLO  = 4'd12,
    ALU_MULT  = 4'd13,
    ALU_MULTU = 4'd14,
    ALU_PASSA = 4'd15
  } aluOp_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } mulState_t;

  localparam int LUI_SHIFT = 16;

  function automatic logic isMulOp(input aluOp_t op);
    return (op == ALU_MULT) || (op == ALU_MULTU);
  endfunction

  function automatic logic readsHiLo(input aluOp_t op);
    return (op == ALU_MFHI) || (op == ALU_MFLO);
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Decode-to-EX inputs and EX-to-MEM outputs of the execute stage.
interface exec_unit_if #(
  parameter int W = 32
);
  logic [3:0]   dALUCtrl;
  logic         dALUSrc;
  logic [W-1:0] dBusA, dBusB, dImm;
  logic         dMemWr, dMemtoReg, dRegWr, dloadext, dJump, dJal;
  logic [1:0]   dDsize, dFPoint;
  logic [4:0]   dRw;
  logic [W-1:0] dDelayslot2;

  logic         qMemWr, qMemtoReg, qRegWr, qloadext, qJump, qJal;
  logic [1:0]   qDsize, qFPoint;
  logic [4:0]   qRw;
  logic [W-1:0] qExecResult, qBusB, qDelayslot2;
  logic         stall;

  modport master (
    output dALUCtrl, dALUSrc, dBusA, dBusB, dImm,
           dMemWr, dMemtoReg, dRegWr, dloadext, dJump, dJal,
           dDsize, dFPoint, dRw, dDelayslot2,
    input  qMemWr, qMemtoReg, qRegWr, qloadext, qJump, qJal,
           qDsize, qFPoint, qRw, qExecResult, qBusB, qDelayslot2, stall
  );

  modport slave (
    input  dALUCtrl, dALUSrc, dBusA, dBusB, dImm,
           dMemWr, dMemtoReg, dRegWr, dloadext, dJump, dJal,
           dDsize, dFPoint, dRw, dDelayslot2,
    output qMemWr, qMemtoReg, qRegWr, qloadext, qJump, qJal,
           qDsize, qFPoint, qRw, qExecResult, qBusB, qDelayslot2, stall
  );
endinterface

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: one partial product per cycle on operand
// magnitudes, with the sign applied to the final sum.
module seq_mult
  import cpu_pkg::*;
#(
  parameter int W         = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   opA,
  input  logic [W-1:0]   opB,
  input  logic           isSigned,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(MUL_ITERS + 1);

  mulState_t      state, nextState;
  logic [CW-1:0]  count;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mplier;
  logic           negate;

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sgn);
    return (sgn && v[W-1]) ? (~v + W'(1)) : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MS_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      MS_IDLE: if (start) nextState = MS_BUSY;
      MS_BUSY: if (count == CW'(1)) nextState = MS_DONE;
      MS_DONE: nextState = MS_IDLE;
      default: nextState = MS_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != MS_IDLE);
    done    = (state == MS_DONE);
    product = negate ? (~acc + (2*W)'(1)) : acc;
  end

  // Load magnitudes on start, then one shift-add step per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      negate <= 1'b0;
    end else if (state == MS_IDLE && start) begin
      count  <= CW'(MUL_ITERS);
      mcand  <= {{W{1'b0}}, magnitude(opA, isSigned)};
      mplier <= magnitude(opB, isSigned);
      acc    <= '0;
      negate <= isSigned & (opA[W-1] ^ opB[W-1]);
    end else if (state == MS_BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: EX pipeline register, inline ALU, HI/LO registers and the
// multiply interlock in front of the sequential multiplier.
module exec_unit
  import cpu_pkg::*;
#(
  parameter int W         = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  exec_unit_if.slave bus
);
  typedef struct packed {
    aluOp_t       aluCtrl;
    logic         aluSrc;
    logic [W-1:0] busA;
    logic [W-1:0] busB;
    logic [W-1:0] imm;
    logic         memWr, memtoReg, regWr, loadext, jump, jal;
    logic [1:0]   dsize;
    logic [1:0]   fpoint;
    logic [4:0]   rw;
    logic [W-1:0] delayslot2;
  } exReg_t;

  exReg_t              dIn, ex_p1;
  logic [W-1:0]        opB, aluResult, hi, lo;
  logic signed [W-1:0] opAS, opBS;
  logic [4:0]          shamt;
  logic                mulOp, stall, bubble, mulStart, mulBusy, mulDone;
  logic [2*W-1:0]      mulProduct;

  always_comb begin
    dIn            = '0;
    dIn.aluCtrl    = aluOp_t'(bus.dALUCtrl);
    dIn.aluSrc     = bus.dALUSrc;
    dIn.busA       = bus.dBusA;
    dIn.busB       = bus.dBusB;
    dIn.imm        = bus.dImm;
    dIn.memWr      = bus.dMemWr;
    dIn.memtoReg   = bus.dMemtoReg;
    dIn.regWr      = bus.dRegWr;
    dIn.loadext    = bus.dloadext;
    dIn.jump       = bus.dJump;
    dIn.jal        = bus.dJal;
    dIn.dsize      = bus.dDsize;
    dIn.fpoint     = bus.dFPoint;
    dIn.rw         = bus.dRw;
    dIn.delayslot2 = bus.dDelayslot2;
  end

  // Stage p1: EX register, held while the interlock is active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ex_p1 <= '0;
    else if (!stall) ex_p1 <= dIn;
  end

  assign mulOp    = isMulOp(ex_p1.aluCtrl);
  assign stall    = (mulOp || readsHiLo(ex_p1.aluCtrl)) && mulBusy;
  assign mulStart = mulOp && !mulBusy;
  assign bubble   = stall || mulOp;

  seq_mult #(.W(W), .MUL_ITERS(MUL_ITERS)) uMult (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mulStart),
    .opA      (ex_p1.busA),
    .opB      (opB),
    .isSigned (ex_p1.aluCtrl == ALU_MULT),
    .busy     (mulBusy),
    .done     (mulDone),
    .product  (mulProduct)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (mulDone) begin
      {hi, lo} <= mulProduct;
    end
  end

  assign opB   = ex_p1.aluSrc ? ex_p1.imm : ex_p1.busB;
  assign opAS  = ex_p1.busA;
  assign opBS  = opB;
  assign shamt = opB[4:0];

  always_comb begin
    aluResult = '0;
    case (ex_p1.aluCtrl)
      ALU_ADD:   aluResult = ex_p1.busA + opB;
      ALU_SUB:   aluResult = ex_p1.busA - opB;
      ALU_AND:   aluResult = ex_p1.busA & opB;
      ALU_OR:    aluResult = ex_p1.busA | opB;
      ALU_XOR:   aluResult = ex_p1.busA ^ opB;
      ALU_SLL:   aluResult = ex_p1.busA << shamt;
      ALU_SRL:   aluResult = ex_p1.busA >> shamt;
      ALU_SRA:   aluResult = opAS >>> shamt;
      ALU_SLT:   aluResult = {{(W-1){1'b0}}, (opAS < opBS)};
      ALU_SLTU:  aluResult = {{(W-1){1'b0}}, (ex_p1.busA < opB)};
      ALU_LUI:   aluResult = opB << LUI_SHIFT;
      ALU_MFHI:  aluResult = hi;
      ALU_MFLO:  aluResult = lo;
      ALU_PASSA: aluResult = ex_p1.busA;
      default:   aluResult = '0;
    endcase
  end

  // Stage p1 -> MEM: combinational outputs, controls squashed on a bubble
  assign bus.stall       = stall;
  assign bus.qMemWr      = ex_p1.memWr    & ~bubble;
  assign bus.qMemtoReg   = ex_p1.memtoReg & ~bubble;
  assign bus.qRegWr      = ex_p1.regWr    & ~bubble;
  assign bus.qloadext    = ex_p1.loadext  & ~bubble;
  assign bus.qJump       = ex_p1.jump     & ~bubble;
  assign bus.qJal        = ex_p1.jal      & ~bubble;
  assign bus.qDsize      = ex_p1.dsize;
  assign bus.qFPoint     = ex_p1.fpoint;
  assign bus.qRw         = ex_p1.rw;
  assign bus.qExecResult = aluResult;
  assign bus.qBusB       = ex_p1.busB;
  assign bus.qDelayslot2 = ex_p1.delayslot2;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed ALU, pass-through, multiplier
// interlock and reset vectors with hand-computed results.
module tb_exec_unit;
  import cpu_pkg::*;

  localparam int W         = 32;
  localparam int MUL_ITERS = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exec_unit_if #(.W(W)) bus ();

  exec_unit #(.W(W), .MUL_ITERS(MUL_ITERS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [79:0]  side;
  } exp_t;

  exp_t sb[$];
  exp_t mon;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [79:0] sideOut();
    return {bus.qBusB, bus.qDelayslot2, bus.qMemWr, bus.qMemtoReg, bus.qRegWr,
            bus.qloadext, bus.qJump, bus.qJal, bus.qDsize, bus.qFPoint, bus.qRw, 1'b0};
  endfunction

  function automatic logic [79:0] sideIn();
    return {bus.dBusB, bus.dDelayslot2, bus.dMemWr, bus.dMemtoReg, bus.dRegWr,
            bus.dloadext, bus.dJump, bus.dJal, bus.dDsize, bus.dFPoint, bus.dRw, 1'b0};
  endfunction

  task automatic nop();
    bus.dALUCtrl    = 4'd0;
    bus.dALUSrc     = 1'b0;
    bus.dBusA       = '0;
    bus.dBusB       = '0;
    bus.dImm        = '0;
    bus.dMemWr      = 1'b0;
    bus.dMemtoReg   = 1'b0;
    bus.dRegWr      = 1'b0;
    bus.dloadext    = 1'b0;
    bus.dJump       = 1'b0;
    bus.dJal        = 1'b0;
    bus.dDsize      = 2'd0;
    bus.dFPoint     = 2'd0;
    bus.dRw         = 5'd0;
    bus.dDelayslot2 = '0;
  endtask

  task automatic drive(input aluOp_t op, input logic src, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] imm);
    nop();
    bus.dALUCtrl    = op;
    bus.dALUSrc     = src;
    bus.dBusA       = a;
    bus.dBusB       = b;
    bus.dImm        = imm;
    bus.dRegWr      = 1'b1;
    bus.dloadext    = 1'b1;
    bus.dDsize      = 2'd2;
    bus.dFPoint     = 2'd1;
    bus.dRw         = 5'(op) + 5'd1;
    bus.dDelayslot2 = 32'h4000_0000 | 32'(op);
  endtask

  // Queue the expectation, wait until the EX register takes the inputs, then idle the bus.
  task automatic issue(input string name, input logic [W-1:0] expRes, input bit push,
                       output int waits);
    logic st;
    if (push) sb.push_back('{name, expRes, sideIn()});
    waits = 0;
    forever begin
      st = bus.stall;
      @(posedge clk);
      #1;
      if (!st) break;
      waits++;
      if (waits > 200) begin
        checks++;
        errors++;
        $display("FAIL %s_capture_timeout actual=%0d required<=200", name, waits);
        break;
      end
    end
    nop();
  endtask

  always @(negedge clk) begin
    if (rst_n && !bus.stall && (bus.qRegWr || bus.qMemWr)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", bus.qExecResult);
      end else begin
        mon = sb.pop_front();
        check({mon.name, "_result"}, 80'(bus.qExecResult), 80'(mon.res));
        check({mon.name, "_fields"}, sideOut(), mon.side);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Inputs active during reset must not be captured
    drive(ALU_ADD, 1'b1, 32'h5, 32'h6, 32'h7);
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", 80'(bus.stall), 80'(0));
    check("reset_result", 80'(bus.qExecResult), 80'(0));
    check("reset_fields", sideOut(), 80'(0));
    nop();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_bubble", sideOut() | 80'(bus.qExecResult) | 80'(bus.stall), 80'(0));

    drive(ALU_ADD, 1'b1, 32'h7FFF_FFFF, 32'h0000_1234, 32'h1);
    issue("add_imm", 32'h8000_0000, 1'b1, w);
    check("add_imm_stall", 80'(bus.stall), 80'(0));
    drive(ALU_ADD, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0);
    issue("add_wrap", 32'h0, 1'b1, w);
    drive(ALU_SUB, 1'b0, 32'h5, 32'h7, 32'h0);
    issue("sub", 32'hFFFF_FFFE, 1'b1, w);
    drive(ALU_AND, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0);
    issue("and", 32'hF000_F000, 1'b1, w);
    drive(ALU_OR, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0);
    issue("or", 32'hFFF0_FFF0, 1'b1, w);
    drive(ALU_XOR, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0);
    issue("xor", 32'h0FF0_0FF0, 1'b1, w);
    drive(ALU_SLL, 1'b1, 32'h1, 32'hAAAA_5555, 32'd36);
    issue("sll_mod32", 32'h10, 1'b1, w);
    drive(ALU_SLL, 1'b0, 32'h1, 32'd31, 32'h0);
    issue("sll31", 32'h8000_0000, 1'b1, w);
    drive(ALU_SRL, 1'b0, 32'hF000_0000, 32'd4, 32'h0);
    issue("srl", 32'h0F00_0000, 1'b1, w);
    drive(ALU_SRA, 1'b0, 32'hF000_0000, 32'd4, 32'h0);
    issue("sra", 32'hFF00_0000, 1'b1, w);
    drive(ALU_SLTU, 1'b0, 32'hF000_0000, 32'd4, 32'h0);
    issue("sltu", 32'h0, 1'b1, w);
    drive(ALU_SLT, 1'b0, 32'hF000_0000, 32'd4, 32'h0);
    issue("slt", 32'h1, 1'b1, w);
    drive(ALU_LUI, 1'b1, 32'h0, 32'h0, 32'h0000_1234);
    issue("lui", 32'h1234_0000, 1'b1, w);
    drive(ALU_PASSA, 1'b0, 32'hDEAD_BEEF, 32'h1, 32'h0);
    issue("pass_a", 32'hDEAD_BEEF, 1'b1, w);

    drive(ALU_ADD, 1'b1, 32'h100, 32'h0000_CAFE, 32'h8);
    bus.dRegWr = 1'b0;
    bus.dMemWr = 1'b1;
    bus.dDsize = 2'd1;
    bus.dRw    = 5'd0;
    bus.dDelayslot2 = 32'h100;
    issue("store", 32'h108, 1'b1, w);

    // Signed multiply followed by dependent HI/LO reads
    drive(ALU_MULT, 1'b0, 32'hFFFF_FFF9, 32'd3, 32'h0);
    issue("mult_neg", 32'h0, 1'b0, w);
    check("mult_bubble", 80'({bus.qMemWr, bus.qRegWr, bus.qMemtoReg, bus.qJump, bus.qJal, bus.qloadext}), 80'(0));
    check("mult_no_stall", 80'(bus.stall), 80'(0));
    drive(ALU_MFLO, 1'b0, 32'h0, 32'h0, 32'h0);
    issue("mflo_neg", 32'hFFFF_FFEB, 1'b1, w);
    check("mflo_interlock", 80'({bus.stall, bus.qRegWr, bus.qMemWr}), 80'(3'b100));
    drive(ALU_MFHI, 1'b0, 32'h0, 32'h0, 32'h0);
    issue("mfhi_neg", 32'hFFFF_FFFF, 1'b1, w);
    check("mflo_stall_cycles", 80'(w), 80'(MUL_ITERS + 1));

    // Unsigned multiply with independent work flowing underneath
    drive(ALU_MULTU, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    issue("multu", 32'h0, 1'b0, w);
    for (int i = 0; i < 5; i++) begin
      drive(ALU_ADD, 1'b1, 32'(i), 32'h0, 32'd100);
      issue("indep_add", 32'(i + 100), 1'b1, w);
      check("indep_add_nostall", 80'(w), 80'(0));
    end
    drive(ALU_MFHI, 1'b0, 32'h0, 32'h0, 32'h0);
    issue("mfhi_multu", 32'hFFFF_FFFE, 1'b1, w);
    drive(ALU_MFLO, 1'b0, 32'h0, 32'h0, 32'h0);
    issue("mflo_multu", 32'h1, 1'b1, w);

    drive(ALU_MULT, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    issue("mult_min", 32'h0, 1'b0, w);
    drive(ALU_MFHI, 1'b0, 32'h0, 32'h0, 32'h0);
    issue("mfhi_min", 32'h0, 1'b1, w);
    drive(ALU_MFLO, 1'b0, 32'h0, 32'h0, 32'h0);
    issue("mflo_min", 32'h8000_0000, 1'b1, w);

    // Reset in the middle of a multiply with an MFHI waiting on it
    drive(ALU_MULT, 1'b0, 32'd5, 32'd6, 32'h0);
    issue("mult_abort", 32'h0, 1'b0, w);
    drive(ALU_MFHI, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_stalled_before", 80'(bus.stall), 80'(1));
    rst_n = 1'b0;
    #1;
    check("abort_stall_drop", 80'(bus.stall), 80'(0));
    check("abort_ctrl_zero", 80'({bus.qMemWr, bus.qRegWr, bus.qMemtoReg, bus.qJump, bus.qJal}), 80'(0));
    nop();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    drive(ALU_MFHI, 1'b0, 32'h0, 32'h0, 32'h0);
    issue("mfhi_after_abort", 32'h0, 1'b1, w);
    drive(ALU_MFLO, 1'b0, 32'h0, 32'h0, 32'h0);
    issue("mflo_after_abort", 32'h0, 1'b1, w);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", 80'(sb.size()), 80'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
